clk_ratio_meter: RTL



---
 rtl/clk_meas_pkg.sv | 14 +
 rtl/sig_sync_edge.sv | 42 ++++
 rtl/clk_ratio_meter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/clk_meas_pkg.sv
// Shared definitions for the clock-ratio measurement path: FSM encoding,
// default counter width and the minimum synchronizer depth.
package clk_meas_pkg;

    localparam int unsigned CNT_W_DEF       = 16;
    localparam int unsigned SYNC_STAGES_MIN = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } meas_state_e;

endpackage : clk_meas_pkg

// File: rtl/sig_sync_edge.sv
// Synchronizes an asynchronous level into the i_clk domain and reports its
// edges.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_sig          : asynchronous input level
//   o_s            : synchronized level (last synchronizer stage)
//   o_rise_c       : combinational, o_s rose this cycle
//   o_fall_c       : combinational, o_s fell this cycle
module sig_sync_edge
    import clk_meas_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_MIN
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_s,
    output logic o_rise_c,
    output logic o_fall_c
);

    // Depths below the minimum are not metastability-safe; clamp them.
    localparam int unsigned N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    logic [N-1:0] sync_q;
    logic         s_d_q;

    // Synchronizer chain plus one extra delay for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[N-2:0], i_sig};
            s_d_q  <= sync_q[N-1];
        end
    end

    assign o_s      = sync_q[N-1];
    assign o_rise_c = sync_q[N-1] & ~s_d_q;
    assign o_fall_c = ~sync_q[N-1] & s_d_q;

endmodule : sig_sync_edge

// File: rtl/clk_ratio_meter.sv
// Measures high time, low time and period of a slow clock-like input in
// i_clk cycles and publishes each completed period with a one-cycle strobe.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_en           : synchronous measurement enable
//   i_sig          : asynchronous signal under measurement
//   o_valid        : one-cycle strobe, o_high/o_low/o_period updated
//   o_high, o_low  : cycles high / low in the last complete period
//   o_period       : o_high + o_low, one bit wider
//   o_timeout      : level, a high or low phase exceeded the counter range
module clk_ratio_meter
    import clk_meas_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_MIN
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_sig,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_high,
    output logic [CNT_W-1:0] o_low,
    output logic [CNT_W:0]   o_period,
    output logic             o_timeout
);

    localparam int unsigned PER_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic s, rise, fall;

    meas_state_e      state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] lcnt_q, lcnt_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic [PER_W-1:0] period_q, period_d;
    logic             timeout_q, timeout_d;

    sig_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_sig    (i_sig),
        .o_s      (s),
        .o_rise_c (rise),
        .o_fall_c (fall)
    );

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            hcnt_q    <= '0;
            lcnt_q    <= '0;
            valid_q   <= 1'b0;
            high_q    <= '0;
            low_q     <= '0;
            period_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            lcnt_q    <= lcnt_d;
            valid_q   <= valid_d;
            high_q    <= high_d;
            low_q     <= low_d;
            period_q  <= period_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state, counter and publish logic.
    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        lcnt_d    = lcnt_q;
        valid_d   = 1'b0;
        high_d    = high_q;
        low_d     = low_q;
        period_d  = period_q;
        timeout_d = timeout_q;

        if (!i_en) begin
            // Abandon any partial measurement; published values and timeout hold.
            state_d = IDLE;
            hcnt_d  = '0;
            lcnt_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    hcnt_d = '0;
                    lcnt_d = '0;
                    if (rise) begin
                        hcnt_d    = CNT_W'(1);
                        timeout_d = 1'b0;
                        state_d   = MEAS_HIGH;
                    end
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        lcnt_d  = CNT_W'(1);
                        state_d = MEAS_LOW;
                    end else if (s) begin
                        if (hcnt_q == CNT_MAX) begin
                            timeout_d = 1'b1;
                            hcnt_d    = '0;
                            lcnt_d    = '0;
                            state_d   = IDLE;
                        end else begin
                            hcnt_d = hcnt_q + CNT_W'(1);
                        end
                    end
                end
                MEAS_LOW: begin
                    // A rise closes the period and starts the next one at once.
                    if (rise) begin
                        valid_d  = 1'b1;
                        high_d   = hcnt_q;
                        low_d    = lcnt_q;
                        period_d = PER_W'(hcnt_q) + PER_W'(lcnt_q);
                        hcnt_d   = CNT_W'(1);
                        lcnt_d   = '0;
                        state_d  = MEAS_HIGH;
                    end else if (!s) begin
                        if (lcnt_q == CNT_MAX) begin
                            timeout_d = 1'b1;
                            hcnt_d    = '0;
                            lcnt_d    = '0;
                            state_d   = IDLE;
                        end else begin
                            lcnt_d = lcnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    hcnt_d  = '0;
                    lcnt_d  = '0;
                end
            endcase
        end
    end

    assign o_valid   = valid_q;
    assign o_high    = high_q;
    assign o_low     = low_q;
    assign o_period  = period_q;
    assign o_timeout = timeout_q;

endmodule : clk_ratio_meter
